wb_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline write-back stream (from the MEM/WB register) and a long-latency unit (LU: multi-cycle divider or uncached load return). Pipeline writes always win. LU results are buffered in a small FIFO and drained into free write-port cycles. A starvation counter requests pipeline bubbles when the FIFO cannot drain, and stale buffered results are killed so that an older LU result never overwrites a newer pipeline write.

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, long-latency results wait in a FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled with `define WB_ARB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_wd,
  input  logic [31:0] wb_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wd,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stallreq
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);

  logic [4:0]        wd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  alive;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic              stallreq_q;

  logic full, empty, live, head_alive, head_dead, drain, pop, push, bypass;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign lu_ready   = !rst && !full;
  assign live       = wb_wreg && (wb_wd != 5'd0);
  assign head_alive = !empty && alive[rd_ptr];
  assign head_dead  = !empty && !alive[rd_ptr];
  assign drain      = !rst && !live && head_alive;
  assign pop        = drain || head_dead;
  assign stallreq   = stallreq_q;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = !rst && empty && !live && lu_valid && (lu_wd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = lu_valid && lu_ready && (lu_wd != 5'd0) && !bypass;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    if (!rst) begin
      if (live) begin
        rf_we    = 1'b1;
        rf_waddr = wb_wd;
        rf_wdata = wb_wdata;
      end else if (head_alive) begin
        rf_we    = 1'b1;
        rf_waddr = wd_mem[rd_ptr];
        rf_wdata = data_mem[rd_ptr];
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = lu_wd;
        rf_wdata = lu_wdata;
      end
    end
  end

  // Payload storage carries no reset; alive bits qualify every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      wd_mem[wr_ptr]   <= lu_wd;
      data_mem[wr_ptr] <= lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      alive      <= '0;
      starve_cnt <= '0;
      stallreq_q <= 1'b0;
    end else begin
      // A same-cycle push is younger than the pipeline write, so it is set after the kill.
      for (int i = 0; i < DEPTH; i++) begin
        if (live && (wd_mem[i] == wb_wd)) alive[i] <= 1'b0;
      end
      if (push) begin
        alive[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drain || empty) begin
        starve_cnt <= '0;
      end else if (head_alive && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      if (drain) begin
        stallreq_q <= 1'b0;
      end else if (head_alive && (starve_cnt >= SW'(STARVE_LIMIT - 1))) begin
        stallreq_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wb_wreg, lu_valid;
  logic [4:0]  wb_wd, lu_wd;
  logic [31:0] wb_wdata, lu_wdata;
  logic        lu_ready, rf_we, stallreq;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_wd(lu_wd), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] data;
    bit          alive;
  } entry_t;

  entry_t q[$];
  int     m_cnt;
  bit     m_stall, stall_prev;
  int     n_checks, n_pass;
  int     lu_writes_5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic step(input bit r, input bit w, input logic [4:0] wd, input logic [31:0] wdat,
                      input bit lv, input logic [4:0] lwd, input logic [31:0] ldat);
    bit e_live, h_alive, e_byp, e_ready, e_we, drain, popd;
    logic [4:0] e_addr;
    logic [31:0] e_data;
    int sz;
    @(negedge clk);
    if (stall_prev) w = 1'b0;
    rst = r; wb_wreg = w; wb_wd = wd; wb_wdata = wdat;
    lu_valid = lv; lu_wd = lwd; lu_wdata = ldat;
    #1;
    sz      = q.size();
    e_live  = !r && w && (wd != 0);
    h_alive = (sz > 0) && q[0].alive;
    e_byp   = BYP && !r && (sz == 0) && !e_live && lv && (lwd != 0);
    e_ready = !r && (sz < DEPTH);
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (!r) begin
      if (e_live)       begin e_we = 1'b1; e_addr = wd;       e_data = wdat;      end
      else if (h_alive) begin e_we = 1'b1; e_addr = q[0].wd;  e_data = q[0].data; end
      else if (e_byp)   begin e_we = 1'b1; e_addr = lwd;      e_data = ldat;      end
    end
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, e_ready});
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("stallreq", {31'd0, stallreq}, {31'd0, m_stall});
    if (e_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
      chk("rf_wdata", rf_wdata, e_data);
      if (!e_live && e_addr == 5'd5) lu_writes_5++;
    end
    stall_prev = m_stall;
    @(posedge clk);
    if (r) begin
      q.delete(); m_cnt = 0; m_stall = 1'b0;
    end else begin
      drain = h_alive && !e_live;
      popd  = (sz > 0) && (!h_alive || drain);
      if (drain || sz == 0) m_cnt = 0;
      else if (h_alive) begin
        if (m_cnt < STARVE_LIMIT) m_cnt++;
        if (m_cnt == STARVE_LIMIT) m_stall = 1'b1;
      end
      if (drain) m_stall = 1'b0;
      if (popd) void'(q.pop_front());
      if (e_live) foreach (q[i]) if (q[i].wd == wd) q[i].alive = 1'b0;
      if (lv && e_ready && (lwd != 0) && !e_byp) q.push_back('{wd: lwd, data: ldat, alive: 1'b1});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 5'd9, 32'h99);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_cnt = 0; m_stall = 0; stall_prev = 0; lu_writes_5 = 0;
    rst = 1; wb_wreg = 0; wb_wd = 0; wb_wdata = 0; lu_valid = 0; lu_wd = 0; lu_wdata = 0;

    // Single LU result with idle pipeline.
    do_reset();
    step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    idle(2);
    chk("lu_r5_written_once", lu_writes_5, 1);

    // Fill FIFO behind a continuous pipeline write to r1, then starve until stallreq.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 5'd1, 32'h100 + i, 1, 5'd10 + 5'(i), 32'hA0 + i);
    for (int i = 0; i < STARVE_LIMIT + 6; i++) step(0, 1, 5'd1, 32'h200 + i, 1, 5'd20, 32'hBB);
    idle(8);

    // Kill: buffered r7 overwritten by newer pipeline write.
    step(0, 1, 5'd1, 32'h1, 1, 5'd7, 32'h11);
    step(0, 1, 5'd7, 32'h22, 0, 0, 0);
    idle(3);

    // Same-cycle pipeline r3 and LU r3: LU entry is younger and survives.
    step(0, 1, 5'd3, 32'h3, 1, 5'd3, 32'h33);
    idle(3);

    // r0 from LU dropped; pipeline write to r0 does not block a drain.
    step(0, 0, 0, 0, 1, 5'd0, 32'hBAD);
    step(0, 1, 5'd2, 32'h2, 1, 5'd4, 32'h44);
    step(0, 1, 5'd0, 32'h5, 0, 0, 0);
    idle(2);

    // Reset with entries buffered.
    for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 32'h7, 1, 5'd12 + 5'(i), 32'hC0 + i);
    step(1, 1, 5'd1, 32'h7, 0, 0, 0);
    idle(4);

    // Random traffic with small register range to provoke kills.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
